// File: rtl/tcon_rr_sched.sv
// Round-robin scheduler sharing a 2:1 byte-select datapath between bank A and bank B.
// Grants are bounded to MAX_BURST transfers so neither bank can starve the other.
// The selected byte lands in a single-entry registered output slot (1-cycle latency).
module tcon_rr_sched #(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_last;
  logic          w_last_d;
  logic          r_sel;
  logic          w_sel_d;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_out_src;

  logic          w_slot_free;
  logic          w_xfer_a;
  logic          w_xfer_b;
  logic [CW-1:0] w_cnt_inc;
  logic          w_at_limit;

  // Ready depends only on grant state and slot occupancy, never on the requesters' valids.
  assign w_slot_free = !r_out_valid || out_ready;
  assign a_ready     = (r_state == StGntA) && w_slot_free;
  assign b_ready     = (r_state == StGntB) && w_slot_free;
  assign w_xfer_a    = a_valid && a_ready;
  assign w_xfer_b    = b_valid && b_ready;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_at_limit  = (w_cnt_inc == CW'(MAX_BURST));

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign busy      = (r_state != StIdle);

  // Next-state arbitration: tie goes to the bank not granted last; burst limit counts transfers.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        if (a_valid && (!b_valid || !r_last)) begin
          w_state_d = StGntA;
          w_cnt_d   = '0;
          w_last_d  = 1'b1;
        end else if (b_valid) begin
          w_state_d = StGntB;
          w_cnt_d   = '0;
          w_last_d  = 1'b0;
        end
      end
      StGntA: begin
        if (w_xfer_a) begin
          if (w_at_limit) begin
            w_cnt_d = '0;
            if (b_valid) begin
              w_state_d = StGntB;
              w_last_d  = 1'b0;
            end
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end else if (!a_valid) begin
          w_cnt_d = '0;
          if (b_valid) begin
            w_state_d = StGntB;
            w_last_d  = 1'b0;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StGntB: begin
        if (w_xfer_b) begin
          if (w_at_limit) begin
            w_cnt_d = '0;
            if (a_valid) begin
              w_state_d = StGntA;
              w_last_d  = 1'b1;
            end
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end else if (!b_valid) begin
          w_cnt_d = '0;
          if (a_valid) begin
            w_state_d = StGntA;
            w_last_d  = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Select follows the next grant; idle keeps the previous value so the mux never glitches.
  always_comb begin
    w_sel_d = r_sel;
    if (w_state_d == StGntA) begin
      w_sel_d = 1'b1;
    end else if (w_state_d == StGntB) begin
      w_sel_d = 1'b0;
    end
  end

  // Grant state, burst counter, last-granted bank and select register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_last  <= w_last_d;
      r_sel   <= w_sel_d;
    end
  end

  // Output slot: load on transfer, clear on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_xfer_a) begin
      r_out_valid <= 1'b1;
      r_out_data  <= a_data;
      r_out_src   <= 1'b1;
    end else if (w_xfer_b) begin
      r_out_valid <= 1'b1;
      r_out_data  <= b_data;
      r_out_src   <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcon_rr_sched.sv
// Directed bench for tcon_rr_sched: transaction-level reference model, per-cycle compare,
// an order scoreboard, and literal expectations for each scenario.
module tb_tcon_rr_sched;

  localparam int MaxBurst = 4;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic       busy;

  tcon_rr_sched #(
    .DW       (8),
    .MAX_BURST(MaxBurst),
    .CW       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (grant = 0 none, 1 bank A, 2 bank B) ----------------
  int         m_grant = 0;
  int         m_cnt   = 0;
  logic       m_last  = 1'b0;
  logic       m_sel   = 1'b0;
  logic       m_ov    = 1'b0;
  logic [7:0] m_od    = 8'h00;
  logic       m_os    = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  int         mx_nxt;
  int         mx_other;
  logic       mx_acc;
  logic       mx_vld[3];
  logic [7:0] mx_dat[3];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_grant = 0; m_cnt = 0; m_last = 1'b0; m_sel = 1'b0;
        m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0;
        exp_q.delete();
      end else begin
        mx_vld[0] = 1'b0; mx_vld[1] = a_valid; mx_vld[2] = b_valid;
        mx_dat[0] = 8'h00; mx_dat[1] = a_data; mx_dat[2] = b_data;
        mx_acc = (m_grant != 0) && mx_vld[m_grant] && (!m_ov || out_ready);
        mx_nxt = m_grant;
        if (m_grant == 0) begin
          if (mx_vld[1] && mx_vld[2]) mx_nxt = m_last ? 2 : 1;
          else if (mx_vld[1]) mx_nxt = 1;
          else if (mx_vld[2]) mx_nxt = 2;
          if (mx_nxt != 0) begin m_cnt = 0; m_last = (mx_nxt == 1); end
        end else begin
          mx_other = 3 - m_grant;
          if (mx_acc) begin
            m_cnt++;
            if (m_cnt == MaxBurst) begin
              m_cnt = 0;
              if (mx_vld[mx_other]) begin mx_nxt = mx_other; m_last = (mx_other == 1); end
            end
          end else if (!mx_vld[m_grant]) begin
            mx_nxt = mx_vld[mx_other] ? mx_other : 0;
            m_cnt  = 0;
            if (mx_nxt != 0) m_last = (mx_nxt == 1);
          end
        end
        if (mx_acc) begin
          m_ov = 1'b1; m_od = mx_dat[m_grant]; m_os = (m_grant == 1);
          exp_q.push_back({m_os, m_od});
        end else if (m_ov && out_ready) begin
          m_ov = 1'b0;
        end
        if (mx_nxt == 1) m_sel = 1'b1;
        else if (mx_nxt == 2) m_sel = 1'b0;
        m_grant = mx_nxt;
      end
    end
  end

  // ---------------- per-cycle compare, sampled on the falling edge ----------------
  logic [8:0] sb_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("a_ready", 32'(a_ready), 32'((m_grant == 1) && (!m_ov || out_ready)));
        check("b_ready", 32'(b_ready), 32'((m_grant == 2) && (!m_ov || out_ready)));
        check("sel", 32'(sel), 32'(m_sel));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_src", 32'(out_src), 32'(m_os));
        check("busy", 32'(busy), 32'(m_grant != 0));
        if (!rst && out_valid && out_ready) begin
          got_q.push_back({out_src, out_data});
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
          end else begin
            sb_exp = exp_q.pop_front();
            check("sb_order", 32'({out_src, out_data}), 32'(sb_exp));
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic       a_on, b_on;
  int         a_idx, b_idx, a_lim, b_lim;
  logic [7:0] a_base, a_step, b_base, b_step;
  logic [8:0] exp_seq[$];

  task automatic drive();
    a_data  = 8'(a_base + 8'(a_idx) * a_step);
    b_data  = 8'(b_base + 8'(b_idx) * b_step);
    a_valid = a_on && (a_idx < a_lim);
    b_valid = b_on && (b_idx < b_lim);
  endtask

  task automatic cycle();
    logic fa, fb;
    @(negedge clk);
    fa = !rst && a_valid && a_ready;
    fb = !rst && b_valid && b_ready;
    @(posedge clk);
    #1;
    if (fa) a_idx++;
    if (fb) b_idx++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_idx = 0;
    b_idx = 0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic check_seq(input string name);
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < got_q.size()) check(name, 32'(got_q[i]), 32'(exp_seq[i]));
      else check({name, "_missing"}, 32'(got_q.size()), 32'(exp_seq.size()));
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    a_on = 1'b1; b_on = 1'b1; a_lim = 1000; b_lim = 1000;
    a_base = 8'hA0; a_step = 8'h01; b_base = 8'hB0; b_step = 8'h01;
    a_idx = 0; b_idx = 0;
    drive();

    // Reset with both valid, then contention with burst limit.
    cycle();
    chk_en = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_a_ready", 32'(a_ready), 32'(0));
    check("rst_b_ready", 32'(b_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    cycle();
    rst = 1'b0;
    got_q.delete();
    cycle();
    #1;
    check("first_grant_sel", 32'(sel), 32'(1));
    check("first_grant_a_ready", 32'(a_ready), 32'(1));
    check("first_grant_b_ready", 32'(b_ready), 32'(0));
    repeat (11) cycle();
    exp_seq = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3, 9'h0B0, 9'h0B1, 9'h0B2, 9'h0B3, 9'h1A4};
    check_seq("contention_seq");

    // Single requester A streaming six bytes with no gaps after arbitration.
    a_on = 1'b1; b_on = 1'b0; a_base = 8'h11; a_step = 8'h11; a_lim = 6;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle();
      #1;
      if (i > 0) check("single_sel", 32'(sel), 32'(1));
    end
    check("single_accepts", 32'(a_idx), 32'(6));
    repeat (2) cycle();
    exp_seq = '{9'h111, 9'h122, 9'h133, 9'h144, 9'h155, 9'h166};
    check_seq("single_seq");

    // Downstream stall mid-burst; burst resumes and completes its remaining transfers.
    a_on = 1'b1; b_on = 1'b1; a_lim = 1000; b_lim = 1000;
    a_base = 8'h30; a_step = 8'h01; b_base = 8'h40; b_step = 8'h01;
    do_reset();
    repeat (3) cycle();
    out_ready = 1'b0;
    repeat (5) begin
      #1;
      check("stall_a_ready", 32'(a_ready), 32'(0));
      check("stall_out_valid", 32'(out_valid), 32'(1));
      check("stall_out_data", 32'(out_data), 32'(8'h31));
      cycle();
    end
    out_ready = 1'b1;
    repeat (6) cycle();
    check("stall_a_accepts", 32'(a_idx), 32'(4));
    exp_seq = '{9'h130, 9'h131, 9'h132, 9'h133, 9'h040};
    check_seq("stall_seq");

    // A drops after two transfers while B is waiting.
    a_on = 1'b1; b_on = 1'b1; a_lim = 2; b_lim = 1000;
    a_base = 8'hA0; b_base = 8'hB0;
    do_reset();
    repeat (3) cycle();
    #1;
    check("drop_sel_before", 32'(sel), 32'(1));
    cycle();
    #1;
    check("drop_sel_after", 32'(sel), 32'(0));
    check("drop_b_ready", 32'(b_ready), 32'(1));

    // A drops with B idle: scheduler goes idle and sel holds.
    b_on = 1'b0;
    do_reset();
    repeat (4) cycle();
    #1;
    check("drop_idle_busy", 32'(busy), 32'(0));
    check("drop_idle_sel", 32'(sel), 32'(1));
    check("drop_idle_a_ready", 32'(a_ready), 32'(0));

    // Reset pulsed while B holds 0x5A in the slot with two transfers in the burst.
    a_on = 1'b0; b_on = 1'b1; a_lim = 1000; b_lim = 1000;
    a_base = 8'h70; b_base = 8'h59; b_step = 8'h01;
    do_reset();
    repeat (3) cycle();
    out_ready = 1'b0;
    #1;
    check("mid_hold_valid", 32'(out_valid), 32'(1));
    check("mid_hold_data", 32'(out_data), 32'(8'h5A));
    check("mid_hold_sel", 32'(sel), 32'(0));
    rst = 1'b1;
    a_on = 1'b1;
    drive();
    cycle();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_data", 32'(out_data), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_sel", 32'(sel), 32'(0));
    cycle();
    #1;
    check("mid_regrant_sel", 32'(sel), 32'(1));
    check("mid_regrant_a_ready", 32'(a_ready), 32'(1));

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcon_rr_sched.md
Name: tcon_rr_sched

Overview:
- Round-robin scheduler that shares the 2:1 byte-select datapath between two requesters, bank A and bank B.
- Arbitrates between the two, drives the bank-select line (high = bank A, low = bank B), and registers the selected byte into a single-entry output slot.
- Uses valid/ready handshakes on both inputs and on the output.
- Bounds each grant to a configurable burst length so neither requester can starve the other.

Parameters:
- DW, 8, data width of each bank and of the output.
- MAX_BURST, 4, maximum consecutive transfers per grant before the other requester is offered the path (≥1).
- CW, 3, burst counter width; must satisfy 2^CW > MAX_BURST.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- a_valid  in  1  bank A has a byte.
- a_data  in  DW  bank A byte.
- a_ready  out  1  bank A byte accepted this cycle when a_valid is also high.
- b_valid  in  1  bank B has a byte.
- b_data  in  DW  bank B byte.
- b_ready  out  1  bank B byte accepted this cycle when b_valid is also high.
- sel  out  1  mux select to the datapath: 1 = bank A, 0 = bank B.
- out_valid  out  1  output slot holds a byte.
- out_data  out  DW  output byte.
- out_src  out  1  source of out_data: 1 = A, 0 = B.
- out_ready  in  1  downstream consumes the slot when out_valid is also high.
- busy  out  1  state is not IDLE.

Behaviour:
- States:
  - IDLE, GNT_A, GNT_B are registered.
  - cnt (CW bits) counts transfers in the current grant.
  - last (1 bit) records the last-granted bank: 1 = A.
- Reset (rst high at a clock edge) forces:
  - state=IDLE, cnt=0, last=0 (so A wins the first tie).
  - sel=0, out_valid=0, out_data=0, out_src=0.
  - Any byte in the slot is discarded.
  - Reset mid-burst returns everything to these values on the next edge; no transfer completes in that cycle.
- slot_free = !out_valid | out_ready (combinational).
- a_ready = (state==GNT_A) & slot_free; b_ready = (state==GNT_B) & slot_free.
- Ready outputs never depend combinationally on a_valid or b_valid.
- Transfer: X_valid & X_ready at edge T loads out_data=X_data and out_src=X, and sets out_valid=1 at T+1. Input-to-output latency is 1 cycle.
- Slot update:
  - out_valid & out_ready with no new transfer clears out_valid.
  - Simultaneous consume and transfer gives back-to-back output, full throughput: one byte per cycle.
  - With out_ready low and out_valid high, the slot holds out_data and out_src stable.
- IDLE:
  - Only A valid → GNT_A. Only B valid → GNT_B.
  - Both valid → grant the bank ≠ last.
  - Neither valid → stay IDLE.
  - Grant takes effect at the next edge, so arbitration latency is 1 cycle. On entering GNT_X: cnt=0, last=X.
- GNT_X:
  - On each transfer, cnt increments.
  - A transfer that brings cnt to MAX_BURST:
    - If the other bank is valid → GNT_other, cnt=0.
    - Otherwise stay GNT_X with cnt=0.
  - X_valid low:
    - If the other bank is valid → GNT_other.
    - Otherwise → IDLE.
  - Otherwise stay in GNT_X.
- sel:
  - Registered: 1 in GNT_A, 0 in GNT_B.
  - In IDLE, sel holds its previous value and never toggles spuriously.
  - sel is valid at least on every cycle where a_ready or b_ready is high.
- Downstream stall: the grant is held and cnt is frozen; the burst limit counts transfers, not cycles.
- No byte is dropped or duplicated.
- Output order equals acceptance order.
- busy = (state != IDLE).

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 → out_valid=0, out_data=0, sel=0, a_ready=b_ready=0, busy=0. First grant after release is A.
- Single requester A: out_ready=1, A streams 0x11,0x22,…,0x66 continuously → out_data shows the same order 1 cycle after each accept. Grant stays A (cnt wraps at 4) with no gap except the initial arbitration cycle. sel=1 throughout.
- Contention, MAX_BURST=4: both valid continuously, A=0xA0.., B=0xB0.., out_ready=1 → output sequence A0,A1,A2,A3,B0,B1,B2,B3,A4,… out_src toggles every 4 bytes. sel follows the grant.
- Backpressure: out_ready=0 for 5 cycles mid-burst → a_ready=0 during the stall, out_data frozen at the last byte, cnt unchanged. After release the burst completes its remaining transfers and no byte is lost.
- Requester drop: A granted, a_valid falls after 2 transfers while b_valid=1 → next state GNT_B, sel=0 one edge later. If b_valid=0 instead → IDLE, busy=0, sel stays 1.
- Reset mid-operation: rst pulsed while out_valid=1 holding 0x5A in GNT_B with cnt=2 → next cycle out_valid=0, state IDLE, last=0. With both valid, the following grant is A.
